alu_share_ctrl: RTL

//  Two-requester scheduler for the shared 8-bit ALU (ADD/SUB/AND/OR/SHL/SHR).

---
 rtl/alu_share_ctrl_if.sv | 67 ++++++
 rtl/alu_share_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl_if.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl_if
//  Bundles the request, response and status signals of the shared-ALU
//  scheduler so that requesters/consumers and the scheduler connect through
//  one port.
//
//  Parameters
//   DW     operand/result width
//   CNT_W  width of the completed-op counter
//
//  Signals
//   req_valid[1:0]        per-requester request valid (bit i = requester i)
//   req_op0/a0/b0         requester 0 opcode and operands
//   req_op1/a1/b1         requester 1 opcode and operands
//   req_ready[1:0]        per-requester accept strobe (combinational)
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/rsp_id/err   result, issuing requester, illegal-opcode flag
//   busy                  scheduler not idle
//   op_count              completed responses, saturating
//   rsp_carry/rsp_zero    result flags, only when ALU_SHARE_FLAGS_EN is defined
//
//  Modports
//   master  requester/consumer side
//   slave   scheduler side
// ----------------------------------------------------------------------------
interface alu_share_ctrl_if #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
);
  logic [1:0]       req_valid;
  logic [2:0]       req_op0;
  logic [DW-1:0]    req_a0;
  logic [DW-1:0]    req_b0;
  logic [2:0]       req_op1;
  logic [DW-1:0]    req_a1;
  logic [DW-1:0]    req_b1;
  logic [1:0]       req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_data;
  logic             rsp_id;
  logic             rsp_err;
  logic             busy;
  logic [CNT_W-1:0] op_count;
`ifdef ALU_SHARE_FLAGS_EN
  logic             rsp_carry;
  logic             rsp_zero;
`endif

  modport master (
    output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1,
    output rsp_ready,
`ifdef ALU_SHARE_FLAGS_EN
    input  rsp_carry, rsp_zero,
`endif
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy, op_count
  );

  modport slave (
    input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1,
    input  rsp_ready,
`ifdef ALU_SHARE_FLAGS_EN
    output rsp_carry, rsp_zero,
`endif
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy, op_count
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl
//  Two-requester scheduler for a shared DW-bit ALU (ADD/SUB/AND/OR/SHL/SHR).
//  Round-robin arbitration grants one requester, its opcode and operands are
//  latched, the operation executes in one cycle, and a registered result
//  tagged with the requester ID is held until the consumer accepts it.
//  Only one operation is outstanding at a time: IDLE -> EXEC -> RESP -> IDLE.
//
//  Parameters
//   DW         operand/result width
//   CNT_W      width of the saturating completed-op counter
//   PRIO_INIT  requester holding priority after reset (0 or 1)
//
//  Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   bus        alu_share_ctrl_if.slave (requests, response, status)
//
//  Configuration macro
//   ALU_SHARE_FLAGS_EN  adds registered rsp_carry / rsp_zero result flags
// ----------------------------------------------------------------------------
module alu_share_ctrl #(
  parameter int DW        = 8,
  parameter int CNT_W     = 16,
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  alu_share_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             grant_s;
  logic             fire_s;
  logic [1:0]       req_ready_s;
  logic             rsp_done_s;

  logic [2:0]       op_r;
  logic [DW-1:0]    a_r;
  logic [DW-1:0]    b_r;
  logic             id_r;

  logic             busy_r;
  logic             prio_r;
  logic             rsp_valid_r;
  logic [DW-1:0]    rsp_data_r;
  logic             rsp_id_r;
  logic             rsp_err_r;
  logic [CNT_W-1:0] op_count_r;
`ifdef ALU_SHARE_FLAGS_EN
  logic             rsp_carry_r;
  logic             rsp_zero_r;
`endif

  // ALU result; opcodes 6/7 produce zero.
  function automatic logic [DW-1:0] alu_data_f(input logic [2:0] op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    logic [DW-1:0] res;
    case (op)
      3'd0:    res = a + b;
      3'd1:    res = a - b;
      3'd2:    res = a & b;
      3'd3:    res = a | b;
      3'd4:    res = {a[DW-2:0], 1'b0};
      3'd5:    res = {1'b0, a[DW-1:1]};
      default: res = {DW{1'b0}};
    endcase
    return res;
  endfunction

`ifdef ALU_SHARE_FLAGS_EN
  // Carry flag: ADD carry-out, SUB borrow, bit shifted out for shifts.
  function automatic logic alu_carry_f(input logic [2:0] op,
                                       input logic [DW-1:0] a,
                                       input logic [DW-1:0] b);
    logic [DW:0] ext;
    logic        c;
    case (op)
      3'd0: begin
        ext = {1'b0, a} + {1'b0, b};
        c   = ext[DW];
      end
      3'd1: begin
        // Borrow out of the extended subtraction equals unsigned A < B.
        ext = {1'b0, a} - {1'b0, b};
        c   = ext[DW];
      end
      3'd4:    c = a[DW-1];
      3'd5:    c = a[0];
      default: c = 1'b0;
    endcase
    return c;
  endfunction
`endif

  // Next-state, arbitration and accept strobes.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = prio_r;
    fire_s      = 1'b0;
    req_ready_s = 2'b00;
    rsp_done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid != 2'b00) begin
          fire_s = 1'b1;
          if (bus.req_valid == 2'b11) begin
            grant_s = prio_r;
          end else begin
            grant_s = bus.req_valid[1];
          end
          req_ready_s = grant_s ? 2'b10 : 2'b01;
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_nxt_s = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_done_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered busy status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Capture the granted requester's opcode, operands and ID at the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r <= 3'd0;
      a_r  <= {DW{1'b0}};
      b_r  <= {DW{1'b0}};
      id_r <= 1'b0;
    end else if (fire_s) begin
      op_r <= grant_s ? bus.req_op1 : bus.req_op0;
      a_r  <= grant_s ? bus.req_a1  : bus.req_a0;
      b_r  <= grant_s ? bus.req_b1  : bus.req_b0;
      id_r <= grant_s;
    end
  end

  // Execute: register the result in EXEC; hold it through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_r  <= {DW{1'b0}};
      rsp_err_r   <= 1'b0;
      rsp_id_r    <= 1'b0;
`ifdef ALU_SHARE_FLAGS_EN
      rsp_carry_r <= 1'b0;
      rsp_zero_r  <= 1'b0;
`endif
    end else if (state_r == ST_EXEC) begin
      rsp_data_r  <= alu_data_f(op_r, a_r, b_r);
      rsp_err_r   <= (op_r > 3'd5);
      rsp_id_r    <= id_r;
`ifdef ALU_SHARE_FLAGS_EN
      rsp_carry_r <= alu_carry_f(op_r, a_r, b_r);
      rsp_zero_r  <= (alu_data_f(op_r, a_r, b_r) == {DW{1'b0}});
`endif
    end
  end

  // Response valid: raised entering RESP, dropped when the consumer accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      rsp_valid_r <= 1'b1;
    end else if (rsp_done_s) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Completed-op counter (saturating) and round-robin priority update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_r <= {CNT_W{1'b0}};
      prio_r     <= PRIO_INIT;
    end else if (rsp_done_s) begin
      if (op_count_r != {CNT_W{1'b1}}) begin
        op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // The requester just served loses priority.
      prio_r <= ~rsp_id_r;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.busy      = busy_r;
  assign bus.op_count  = op_count_r;
`ifdef ALU_SHARE_FLAGS_EN
  assign bus.rsp_carry = rsp_carry_r;
  assign bus.rsp_zero  = rsp_zero_r;
`endif

endmodule
